wb_master_arbiter: RTL

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_timeout_counter.sv | 35 +++
 rtl/wb_master_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding and grant codes.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_timeout_counter.sv
// Stall watchdog: counts enabled cycles and pulses expire the cycle after the limit is reached.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // A zero limit keeps the counter parked, which disables the watchdog.
  always_ff @(posedge clk) begin
    if (rst || clr || (TIMEOUT_CYCLES == 0)) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (en) begin
      if (count == LIMIT) begin
        count  <= '0;
        expire <= 1'b1;
      end else begin
        count  <= count + CW'(1);
        expire <= 1'b0;
      end
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter with locked bursts and a stall watchdog
// that terminates a hung transfer with err.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_wb_adr,
  input  logic [DATA_WIDTH-1:0] m0_wb_dat_w,
  input  logic [SEL_WIDTH-1:0]  m0_wb_sel,
  input  logic                  m0_wb_we,
  input  logic                  m0_wb_cyc,
  input  logic                  m0_wb_stb,
  output logic [DATA_WIDTH-1:0] m0_wb_dat_r,
  output logic                  m0_wb_ack,
  output logic                  m0_wb_err,
  input  logic [ADDR_WIDTH-1:0] m1_wb_adr,
  input  logic [DATA_WIDTH-1:0] m1_wb_dat_w,
  input  logic [SEL_WIDTH-1:0]  m1_wb_sel,
  input  logic                  m1_wb_we,
  input  logic                  m1_wb_cyc,
  input  logic                  m1_wb_stb,
  output logic [DATA_WIDTH-1:0] m1_wb_dat_r,
  output logic                  m1_wb_ack,
  output logic                  m1_wb_err,
  output logic [ADDR_WIDTH-1:0] s_wb_adr,
  output logic [DATA_WIDTH-1:0] s_wb_dat_w,
  output logic [SEL_WIDTH-1:0]  s_wb_sel,
  output logic                  s_wb_we,
  output logic                  s_wb_cyc,
  output logic                  s_wb_stb,
  input  logic [DATA_WIDTH-1:0] s_wb_dat_r,
  input  logic                  s_wb_ack,
  input  logic                  s_wb_err,
  output logic [1:0]            gnt,
  output logic                  timeout
);

  arb_state_e state, state_nxt;
  logic       last_srv, last_srv_nxt;
  logic       own_cyc;
  logic       wd_en;
  logic       expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_srv <= 1'b1;
      gnt      <= GNT_NONE;
    end else begin
      state    <= state_nxt;
      last_srv <= last_srv_nxt;
      gnt      <= (state_nxt == ST_OWN0) ? GNT_M0 :
                  (state_nxt == ST_OWN1) ? GNT_M1 : GNT_NONE;
    end
  end

  // Ownership is only decided from IDLE, so bursts are never preempted.
  always_comb begin
    state_nxt    = state;
    last_srv_nxt = last_srv;
    case (state)
      ST_IDLE: begin
        if (m0_wb_cyc && (!m1_wb_cyc || last_srv)) begin
          state_nxt    = ST_OWN0;
          last_srv_nxt = 1'b0;
        end else if (m1_wb_cyc) begin
          state_nxt    = ST_OWN1;
          last_srv_nxt = 1'b1;
        end
      end
      ST_OWN0: if (!m0_wb_cyc) state_nxt = ST_IDLE;
      ST_OWN1: if (!m1_wb_cyc) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Owner muxing; an expiring watchdog swallows stb/ack and substitutes err.
  always_comb begin
    s_wb_adr    = '0;
    s_wb_dat_w  = '0;
    s_wb_sel    = '0;
    s_wb_we     = 1'b0;
    s_wb_cyc    = 1'b0;
    s_wb_stb    = 1'b0;
    m0_wb_dat_r = '0;
    m0_wb_ack   = 1'b0;
    m0_wb_err   = 1'b0;
    m1_wb_dat_r = '0;
    m1_wb_ack   = 1'b0;
    m1_wb_err   = 1'b0;
    own_cyc     = 1'b0;
    case (state)
      ST_OWN0: begin
        s_wb_adr    = m0_wb_adr;
        s_wb_dat_w  = m0_wb_dat_w;
        s_wb_sel    = m0_wb_sel;
        s_wb_we     = m0_wb_we;
        s_wb_cyc    = m0_wb_cyc;
        s_wb_stb    = m0_wb_stb & ~expire;
        m0_wb_dat_r = s_wb_dat_r;
        m0_wb_ack   = s_wb_ack & ~expire;
        m0_wb_err   = s_wb_err | expire;
        own_cyc     = m0_wb_cyc;
      end
      ST_OWN1: begin
        s_wb_adr    = m1_wb_adr;
        s_wb_dat_w  = m1_wb_dat_w;
        s_wb_sel    = m1_wb_sel;
        s_wb_we     = m1_wb_we;
        s_wb_cyc    = m1_wb_cyc;
        s_wb_stb    = m1_wb_stb & ~expire;
        m1_wb_dat_r = s_wb_dat_r;
        m1_wb_ack   = s_wb_ack & ~expire;
        m1_wb_err   = s_wb_err | expire;
        own_cyc     = m1_wb_cyc;
      end
      default: ;
    endcase
  end

  assign wd_en   = own_cyc & s_wb_stb & ~s_wb_ack & ~s_wb_err;
  assign timeout = expire;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .en    (wd_en),
    .clr   (~wd_en),
    .expire(expire)
  );

endmodule
